// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// Pure definitions: no latency or flow control of its own.
// Includes the lowest-enabled-channel helper used when a scan starts.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CH_W          = 2;
    localparam int N_CH          = 4;
    localparam int DEFAULT_DWELL = 2;
    localparam int CNT_W         = 4;

    function automatic logic [CH_W-1:0] first_ch(input logic [N_CH-1:0] mask);
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) first_ch = CH_W'(i);
        end
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Finds the next enabled channel strictly above the current one.
// Latency: purely combinational, zero cycles.
// Backpressure: none; none=1 when no higher channel is enabled.
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    output logic [CH_W-1:0] nxt,
    output logic            none
);

    // Walk downwards so the lowest qualifying channel wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) begin
                nxt  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an external 4:1 mux over the enabled channels, capturing y after DWELL cycles each.
// Latency: valid pulses one cycle after edge start+N*DWELL; an empty mask completes at once.
// Backpressure: none; start is only sampled in IDLE. MUX_SCAN_CONT_EN adds port cont for rescans.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DEFAULT_DWELL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            y,
    output logic            S1,
    output logic            S2,
    output logic [N_CH-1:0] sample,
    output logic            valid,
    output logic            busy
`ifdef MUX_SCAN_CONT_EN
    ,
    input  logic            cont
`endif
);

    state_t            state_q, state_n;
    logic [CH_W-1:0]   sel_q, sel_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [N_CH-1:0]   mask_q, mask_n;
    logic [N_CH-1:0]   sample_q, sample_n;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_none;
    logic              launch;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    mux_scan_next u_next (
        .mask (mask_q),
        .cur  (sel_q),
        .nxt  (nxt_ch),
        .none (nxt_none)
    );

    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        cnt_n    = cnt_q;
        mask_n   = mask_q;
        sample_n = sample_q;
        launch   = 1'b0;
        case (state_q)
            IDLE: launch = start;
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    sample_n[sel_q] = y;
                    if (nxt_none) begin
                        state_n = DONE;
                    end else begin
                        sel_n = nxt_ch;
                        cnt_n = DWELL_LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
`ifdef MUX_SCAN_CONT_EN
                launch  = cont;
`endif
            end
            default: state_n = IDLE;
        endcase

        // Mask is captured here so mid-scan changes on ch_mask are ignored.
        if (launch) begin
            mask_n   = ch_mask;
            sample_n = '0;
            if (ch_mask != '0) begin
                state_n = SETTLE;
                sel_n   = first_ch(ch_mask);
                cnt_n   = DWELL_LOAD;
            end else begin
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_n;
            sel_q    <= sel_n;
            cnt_q    <= cnt_n;
            mask_q   <= mask_n;
            sample_q <= sample_n;
        end
    end

    assign {S1, S2} = sel_q;
    assign sample   = sample_q;
    assign valid    = (state_q == DONE);
    assign busy     = (state_q == SETTLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (DWELL 1, 2, 3) share stimulus,
// each driving its own model of the downstream 4:1 mux from i_vec.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [3:0] i_vec = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
    logic       cont = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic s1_a, s2_a, valid_a, busy_a, y_a;
    logic s1_b, s2_b, valid_b, busy_b, y_b;
    logic s1_c, s2_c, valid_c, busy_c, y_c;
    logic [3:0] sample_a, sample_b, sample_c;

    assign y_a = i_vec[{s1_a, s2_a}];
    assign y_b = i_vec[{s1_b, s2_b}];
    assign y_c = i_vec[{s1_c, s2_c}];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .y(y_a),
        .S1(s1_a), .S2(s2_a), .sample(sample_a), .valid(valid_a), .busy(busy_a)
`ifdef MUX_SCAN_CONT_EN
        , .cont(cont)
`endif
    );

    mux_scan_ctrl #(.DWELL(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .y(y_b),
        .S1(s1_b), .S2(s2_b), .sample(sample_b), .valid(valid_b), .busy(busy_b)
`ifdef MUX_SCAN_CONT_EN
        , .cont(cont)
`endif
    );

    mux_scan_ctrl #(.DWELL(3)) dut_c (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .y(y_c),
        .S1(s1_c), .S2(s2_c), .sample(sample_c), .valid(valid_c), .busy(busy_c)
`ifdef MUX_SCAN_CONT_EN
        , .cont(cont)
`endif
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s1_b, s2_b, sample_b, valid_b, busy_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_async: S=%b%b sample=%b valid=%b busy=%b, want all 0",
                     s1_b, s2_b, sample_b, valid_b, busy_b);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({s1_b, s2_b, sample_b, valid_b, busy_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_idle: S=%b%b sample=%b valid=%b busy=%b, want all 0",
                     s1_b, s2_b, sample_b, valid_b, busy_b);
        end
    endtask

    task automatic test_full_scan();
        logic [1:0] exp_sel [8];
        exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        i_vec   = 4'b1010;
        ch_mask = 4'b1111;
        start   = 1'b1;
        step();
        start   = 1'b0;
        ch_mask = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            checks++;
            if ({s1_b, s2_b, busy_b, valid_b} !== {exp_sel[k], 2'b10}) begin
                errors++;
                $display("FAIL full_scan edge%0d: S=%b%b busy=%b valid=%b, want S=%b busy=1 valid=0",
                         k, s1_b, s2_b, busy_b, valid_b, exp_sel[k]);
            end
        end
        step();
        checks++;
        if ({valid_b, busy_b, sample_b} !== {2'b10, 4'b1010}) begin
            errors++;
            $display("FAIL full_scan_done: valid=%b busy=%b sample=%b, want valid=1 busy=0 sample=1010",
                     valid_b, busy_b, sample_b);
        end
        step();
        checks++;
        if ({valid_b, s1_b, s2_b, sample_b} !== {3'b011, 4'b1010}) begin
            errors++;
            $display("FAIL full_scan_hold: valid=%b S=%b%b sample=%b, want valid=0 S=11 sample=1010",
                     valid_b, s1_b, s2_b, sample_b);
        end
        repeat (14) step();
    endtask

    task automatic test_empty_mask();
        ch_mask = 4'b0000;
        start   = 1'b1;
        step();
        start   = 1'b0;
        checks++;
        if ({valid_b, busy_b, sample_b, s1_b, s2_b} !== {2'b10, 4'b0000, 2'b11}) begin
            errors++;
            $display("FAIL empty_done: valid=%b busy=%b sample=%b S=%b%b, want valid=1 busy=0 sample=0000 S=11",
                     valid_b, busy_b, sample_b, s1_b, s2_b);
        end
        step();
        checks++;
        if ({valid_b, busy_b} !== 2'b00) begin
            errors++;
            $display("FAIL empty_after: valid=%b busy=%b, want 0 0", valid_b, busy_b);
        end
        repeat (4) step();
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_sel [6];
        exp_sel = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
        i_vec   = 4'b1110;
        ch_mask = 4'b0101;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            checks++;
            if ({s1_c, s2_c, busy_c, valid_c} !== {exp_sel[k], 2'b10}) begin
                errors++;
                $display("FAIL sparse edge%0d: S=%b%b busy=%b valid=%b, want S=%b busy=1 valid=0",
                         k, s1_c, s2_c, busy_c, valid_c, exp_sel[k]);
            end
        end
        step();
        checks++;
        if ({valid_c, sample_c} !== {1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL sparse_done: valid=%b sample=%b, want valid=1 sample=0100", valid_c, sample_c);
        end
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        i_vec   = 4'b0110;
        ch_mask = 4'b1111;
        start   = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            checks++;
            if ({s1_a, s2_a, busy_a, valid_a} !== {2'(k), 2'b10}) begin
                errors++;
                $display("FAIL held_start edge%0d: S=%b%b busy=%b valid=%b, want S=%0d busy=1 valid=0",
                         k, s1_a, s2_a, busy_a, valid_a, k);
            end
        end
        step();
        checks++;
        if ({valid_a, sample_a} !== {1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL held_start_done: valid=%b sample=%b, want valid=1 sample=0110", valid_a, sample_a);
        end
        step();
        checks++;
        if ({valid_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL held_start_idle: valid=%b busy=%b, want 0 0", valid_a, busy_a);
        end
        step();
        start = 1'b0;
        checks++;
        if ({busy_a, valid_a, s1_a, s2_a} !== 4'b1000) begin
            errors++;
            $display("FAIL held_start_rescan: busy=%b valid=%b S=%b%b, want busy=1 valid=0 S=00",
                     busy_a, valid_a, s1_a, s2_a);
        end
        repeat (20) step();
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        i_vec   = 4'b1011;
        ch_mask = 4'b1111;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (3) step();
        checks++;
        if ({s1_b, s2_b, busy_b, sample_b} !== {3'b011, 4'b0001}) begin
            errors++;
            $display("FAIL mid_scan_pre: S=%b%b busy=%b sample=%b, want S=01 busy=1 sample=0001",
                     s1_b, s2_b, busy_b, sample_b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s1_b, s2_b, sample_b, busy_b, valid_b} !== 8'b0) begin
            errors++;
            $display("FAIL mid_scan_reset: S=%b%b sample=%b busy=%b valid=%b, want all 0",
                     s1_b, s2_b, sample_b, busy_b, valid_b);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (valid_b === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL mid_scan_no_valid: pulses=%0d, want 0", pulses);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        checks++;
        if ({valid_b, s1_b, s2_b} !== 3'b011) begin
            errors++;
            $display("FAIL rescan_edge7: valid=%b S=%b%b, want valid=0 S=11", valid_b, s1_b, s2_b);
        end
        step();
        checks++;
        if ({valid_b, sample_b} !== {1'b1, 4'b1011}) begin
            errors++;
            $display("FAIL rescan_done: valid=%b sample=%b, want valid=1 sample=1011", valid_b, sample_b);
        end
        repeat (12) step();
    endtask

`ifdef MUX_SCAN_CONT_EN
    task automatic test_cont();
        logic [1:0] exp_sel [9];
        exp_sel = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
        i_vec   = 4'b0001;
        cont    = 1'b1;
        ch_mask = 4'b0011;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            checks++;
            if ({s1_a, s2_a, valid_a} !== {exp_sel[k], (k % 3) == 2}) begin
                errors++;
                $display("FAIL cont edge%0d: S=%b%b valid=%b, want S=%b valid=%b",
                         k, s1_a, s2_a, valid_a, exp_sel[k], (k % 3) == 2);
            end
        end
        checks++;
        if (sample_a !== 4'b0001) begin
            errors++;
            $display("FAIL cont_sample: sample=%b, want 0001", sample_a);
        end
        cont = 1'b0;
        repeat (16) step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_scan();
        test_empty_mask();
        test_sparse_mask();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef MUX_SCAN_CONT_EN
        test_cont();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset (ports clk and rst).
REQ-002 Parameter: DWELL, default 2, meaning cycles each channel stays selected before capture (legal 1..15).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  scan request, sampled in IDLE only.
REQ-006 Port: ch_mask  input  4  channel enables; bit n enables mux input i<n>.
REQ-007 Port: y  input  1  output Y of the downstream 4:1 mux.
REQ-008 Port: S1  output  1  mux select MSB.
REQ-009 Port: S2  output  1  mux select LSB; channel = {S1,S2}, so 00 selects i0 and 11 selects i3.
REQ-010 Port: sample  output  4  captured y per channel; bit n belongs to channel n.
REQ-011 Port: valid  output  1  one-cycle pulse; sample is complete.
REQ-012 Port: busy  output  1  high while the block is in SETTLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SETTLE and DONE.
REQ-014 IDLE with start=1 and ch_mask!=0 SHALL, at the same edge:
  - go to SETTLE;
  - set {S1,S2} to the lowest enabled channel;
  - load the dwell counter with DWELL-1;
  - clear sample to 0.
REQ-015 IDLE with start=1 and ch_mask==0 SHALL go to DONE with sample cleared to 0.
REQ-016 ch_mask SHALL be latched at the start edge; later changes SHALL NOT affect the scan in progress.
REQ-017 In SETTLE with counter!=0, the block SHALL decrement the counter each edge and hold {S1,S2}.
REQ-018 In SETTLE with counter==0, the block SHALL, at that edge:
  - write y into sample[{S1,S2}];
  - if a higher latched channel is enabled, select it and reload the counter with DWELL-1;
  - otherwise go to DONE.
REQ-019 Each enabled channel SHALL be selected for exactly DWELL cycles; disabled channels SHALL be skipped with no extra cycles.
REQ-020 For N enabled channels started at edge k, valid SHALL be high during the cycle after edge k+N*DWELL.
REQ-021 DONE SHALL assert valid for exactly one cycle and then return to IDLE.
REQ-022 sample SHALL hold its value from DONE until the next accepted start.
REQ-023 start asserted in SETTLE or DONE SHALL be ignored, with no queuing.
REQ-024 {S1,S2} SHALL hold their last value in IDLE and DONE.
REQ-025 sample bits of masked channels SHALL read 0.

Reset
REQ-026 rst=1 SHALL immediately force the following, without waiting for a clock edge:
  - state IDLE;
  - S1=0, S2=0;
  - sample=0, valid=0, busy=0;
  - dwell counter 0.
REQ-027 Reset during SETTLE SHALL abort the scan with no valid pulse; the first start after reset release SHALL begin a fresh scan.

Configuration
REQ-028 The macro MUX_SCAN_CONT_EN SHALL control continuous mode, as follows.
REQ-029 With MUX_SCAN_CONT_EN defined:
  - the block SHALL have an extra input port cont (1 bit);
  - if cont=1 in DONE, the next edge SHALL go directly to a new scan, as though start had been accepted, using the current ch_mask;
  - valid SHALL still pulse once per completed scan.
REQ-030 Without MUX_SCAN_CONT_EN, port cont SHALL not exist and DONE SHALL always return to IDLE.

Structure
REQ-031 A shared package mux_scan_pkg SHALL hold:
  - the state encoding (IDLE, SETTLE, DONE);
  - the channel-index width (2);
  - the channel count (4);
  - the default DWELL.
REQ-032 One combinational sub-module, mux_scan_next, SHALL take the latched mask and the current channel, and return the next higher enabled channel plus a none flag.
REQ-033 mux_scan_ctrl SHALL instantiate mux_scan_next for channel advance.

Verification
REQ-034 Full scan: DWELL=2, ch_mask=1111, mux inputs i3..i0=1010, start pulse at edge 0 -> {S1,S2}=00,00,01,01,10,10,11,11; valid one cycle after edge 8; sample=1010.
REQ-035 Sparse mask: DWELL=3, ch_mask=0101, i2=1, i0=0 -> only channels 0 and 2 selected, 3 cycles each; valid after edge 6; sample=0100.
REQ-036 Empty mask: ch_mask=0000, start -> busy stays 0; valid after edge 1; sample=0000.
REQ-037 Ignored start: start held high for the whole scan with ch_mask=1111, DWELL=1 -> exactly one valid pulse after edge 4; a new scan begins only after IDLE is re-entered.
REQ-038 Reset mid-scan: rst asserted after edge 3 of a 1111 scan -> S1,S2,sample,busy,valid are 0 immediately; no valid pulse; the next start gives a correct full scan.
REQ-039 MUX_SCAN_CONT_EN with cont=1, ch_mask=0011, DWELL=1 -> valid pulses every 3 cycles; {S1,S2} sequence 00,01 repeats.
